// File: rtl/ysyx_25010008_pkg.sv
// Shared definitions for the memory arbiter slice.
//   arb_state_e : grant FSM states (IDLE plus one state per grantable channel)
//   RESP_*      : AXI response encodings passed through by the arbiter
package ysyx_25010008_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_IFU_R = 2'd1,
    GNT_LSU_R = 2'd2,
    GNT_LSU_W = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_25010008_arb_pick.sv
// Combinational grant chooser used while the arbiter is idle.
// Ports:
//   ifu_rd   : IFU read-address request pending
//   lsu_rd   : LSU read-address request pending
//   lsu_wr   : LSU write request pending (address and data both valid)
//   last_lsu : (YSYX_ARB_RR_EN only) last grant went to the LSU
//   pick     : chosen grant state, IDLE when nothing is requested
// Config macro: YSYX_ARB_RR_EN selects round-robin between IFU and LSU;
// otherwise LSU always beats IFU. LSU write always beats LSU read.
module ysyx_25010008_arb_pick
  import ysyx_25010008_pkg::*;
(
  input  logic       ifu_rd,
  input  logic       lsu_rd,
  input  logic       lsu_wr,
`ifdef YSYX_ARB_RR_EN
  input  logic       last_lsu,
`endif
  output arb_state_e pick
);

  logic lsu_req;
  logic lsu_first;

  always_comb begin
    lsu_req = lsu_rd | lsu_wr;
`ifdef YSYX_ARB_RR_EN
    lsu_first = ~last_lsu;
`else
    lsu_first = 1'b1;
`endif
    pick = IDLE;
    if (lsu_req && (lsu_first || !ifu_rd)) begin
      pick = lsu_wr ? GNT_LSU_W : GNT_LSU_R;
    end else if (ifu_rd) begin
      pick = GNT_IFU_R;
    end
  end

endmodule

// File: rtl/ysyx_25010008_mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI-lite style arbiter.
// A request seen while idle is granted at the next edge; the granted
// master's channels are then wired straight through to mem_* until the
// response handshake, after which one idle cycle always follows.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   ifu_ar*/ifu_r*         : IFU read address / read data channels
//   lsu_ar*/lsu_r*         : LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*  : LSU write address / data / response channels
//   mem_*                  : downstream slave port (full LSU channel set)
// Config macro: YSYX_ARB_RR_EN enables round-robin IFU/LSU arbitration.
module ysyx_25010008_mem_arbiter
  import ysyx_25010008_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  input  logic                ifu_rready,
  // LSU read
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_rready,
  // LSU write
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  input  logic                lsu_bready,
  // downstream slave
  output logic                mem_arvalid,
  output logic [ADDR_W-1:0]   mem_araddr,
  input  logic                mem_arready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  output logic                mem_rready,
  output logic                mem_awvalid,
  output logic [ADDR_W-1:0]   mem_awaddr,
  input  logic                mem_awready,
  output logic                mem_wvalid,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_wready,
  input  logic                mem_bvalid,
  input  logic [1:0]          mem_bresp,
  output logic                mem_bready
);

  arb_state_e state;
  arb_state_e pick;

`ifdef YSYX_ARB_RR_EN
  logic last_lsu;
`endif

  ysyx_25010008_arb_pick u_pick (
    .ifu_rd   (ifu_arvalid),
    .lsu_rd   (lsu_arvalid),
    .lsu_wr   (lsu_awvalid & lsu_wvalid),
`ifdef YSYX_ARB_RR_EN
    .last_lsu (last_lsu),
`endif
    .pick     (pick)
  );

  // Grant register. Only the response handshake releases a grant, so a
  // master dropping its request valid mid-grant keeps ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef YSYX_ARB_RR_EN
      last_lsu <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= pick;
`ifdef YSYX_ARB_RR_EN
          if (pick != IDLE) last_lsu <= (pick != GNT_IFU_R);
`endif
        end
        GNT_IFU_R, GNT_LSU_R: if (mem_rvalid && mem_rready) state <= IDLE;
        GNT_LSU_W:            if (mem_bvalid && mem_bready) state <= IDLE;
        default:              state <= IDLE;
      endcase
    end
  end

  // Pass-through mux: everything not owned by the current grant is zero,
  // which also covers the all-zero outputs in IDLE and after reset.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = RESP_OKAY;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = RESP_OKAY;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = RESP_OKAY;
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    mem_rready  = 1'b0;
    mem_awvalid = 1'b0;
    mem_awaddr  = '0;
    mem_wvalid  = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_bready  = 1'b0;
    case (state)
      GNT_IFU_R: begin
        mem_arvalid = ifu_arvalid;
        mem_araddr  = ifu_araddr;
        ifu_arready = mem_arready;
        ifu_rvalid  = mem_rvalid;
        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        mem_rready  = ifu_rready;
      end
      GNT_LSU_R: begin
        mem_arvalid = lsu_arvalid;
        mem_araddr  = lsu_araddr;
        lsu_arready = mem_arready;
        lsu_rvalid  = mem_rvalid;
        lsu_rdata   = mem_rdata;
        lsu_rresp   = mem_rresp;
        mem_rready  = lsu_rready;
      end
      GNT_LSU_W: begin
        mem_awvalid = lsu_awvalid;
        mem_awaddr  = lsu_awaddr;
        lsu_awready = mem_awready;
        mem_wvalid  = lsu_wvalid;
        mem_wdata   = lsu_wdata;
        mem_wstrb   = lsu_wstrb;
        lsu_wready  = mem_wready;
        lsu_bvalid  = mem_bvalid;
        lsu_bresp   = mem_bresp;
        mem_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Self-checking bench for ysyx_25010008_mem_arbiter: directed scenarios
// followed by randomized traffic against a transaction-level model.
module tb_ysyx_25010008_mem_arbiter;

`ifdef YSYX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [1:0]  lsu_bresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
  logic [31:0] mem_awaddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  mem_bresp;

  int errors = 0;
  int checks = 0;

  ysyx_25010008_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rready(mem_rready),
    .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_awready(mem_awready),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wready(mem_wready),
    .mem_bvalid(mem_bvalid), .mem_bresp(mem_bresp), .mem_bready(mem_bready)
  );

  always #5 clk = ~clk;

  logic [255:0] all_out;
  logic [127:0] lsu_out;
  assign all_out = 256'({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
                         lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
                         lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
                         mem_arvalid, mem_araddr, mem_rready, mem_awvalid, mem_awaddr,
                         mem_wvalid, mem_wdata, mem_wstrb, mem_bready});
  assign lsu_out = 128'({lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
                         lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp});

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 0;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rresp = '0;
    mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = '0;
  endtask

  task automatic apply_reset;
    idle_inputs;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1;
    ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; lsu_arvalid = 1;
    mem_rvalid = 1; mem_bvalid = 1; mem_rdata = 32'hFFFF_FFFF; mem_arready = 1;
    tick; tick; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    lsu_wdata = 32'hA5A5_A5A5; mem_bresp = 2'b10;
    tick; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", all_out); end
    idle_inputs;
    rst = 0;
    tick; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle got=%h exp=0", all_out); end
  endtask

  task automatic test_ifu_read;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_rready = 1; #1;
    checks++;
    if (mem_arvalid !== 1'b0 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL ifu_req_cycle mem_arvalid=%b ifu_arready=%b exp=0,0", mem_arvalid, ifu_arready);
    end
    tick; #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin
      errors++; $display("FAIL ifu_fwd mem_arvalid=%b addr=%h exp=1,80000000", mem_arvalid, mem_araddr);
    end
    mem_arready = 1; #1;
    checks++;
    if (ifu_arready !== 1'b1) begin errors++; $display("FAIL ifu_arready got=%b exp=1", ifu_arready); end
    tick;
    ifu_arvalid = 0; mem_arready = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678; mem_rresp = 2'b00; #1;
    checks++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h1234_5678 || mem_rready !== 1'b1) begin
      errors++; $display("FAIL ifu_rdata rvalid=%b data=%h rready=%b exp=1,12345678,1", ifu_rvalid, ifu_rdata, mem_rready);
    end
    checks++;
    if (lsu_out !== '0) begin errors++; $display("FAIL ifu_lsu_quiet got=%h exp=0", lsu_out); end
    tick;
    mem_rvalid = 0; mem_rdata = '0; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL ifu_release_idle got=%h exp=0", all_out); end
    idle_inputs;
  endtask

  task automatic test_contention;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; ifu_rready = 1;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0200; lsu_rready = 1;
    tick; #1;
    mem_arready = 1; #1;
    checks++;
    if (mem_araddr !== 32'h8000_0200 || lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL contention_lsu_first addr=%h lsu_ar=%b ifu_ar=%b exp=80000200,1,0", mem_araddr, lsu_arready, ifu_arready);
    end
    tick;
    lsu_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D; #1;
    checks++;
    if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h0BAD_F00D || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL contention_lsu_data rvalid=%b data=%h ifu_ar=%b exp=1,0badf00d,0", lsu_rvalid, lsu_rdata, ifu_arready);
    end
    tick;
    mem_rvalid = 0; mem_arready = 1; #1;
    checks++;
    if (ifu_arready !== 1'b0 || mem_arvalid !== 1'b0) begin
      errors++; $display("FAIL contention_gap ifu_ar=%b mem_arvalid=%b exp=0,0", ifu_arready, mem_arvalid);
    end
    tick; #1;
    checks++;
    if (ifu_arready !== 1'b1 || mem_araddr !== 32'h8000_0100) begin
      errors++; $display("FAIL contention_ifu_next ifu_ar=%b addr=%h exp=1,80000100", ifu_arready, mem_araddr);
    end
    tick;
    ifu_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0001;
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_lsu_write;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010;
    lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; lsu_bready = 1;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0300; #1;
    checks++;
    if (lsu_awready !== 1'b0 || mem_awvalid !== 1'b0) begin
      errors++; $display("FAIL wr_req_cycle awready=%b mem_awvalid=%b exp=0,0", lsu_awready, mem_awvalid);
    end
    tick;
    mem_awready = 1; mem_wready = 1; #1;
    checks++;
    if (mem_awvalid !== 1'b1 || mem_awaddr !== 32'h8000_0010 || mem_wvalid !== 1'b1 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0011 || mem_arvalid !== 1'b0) begin
      errors++; $display("FAIL wr_fwd aw=%b/%h w=%b/%h/%b ar=%b exp=1/80000010 1/deadbeef/0011 0",
                         mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_arvalid);
    end
    checks++;
    if (lsu_awready !== 1'b1 || lsu_wready !== 1'b1) begin
      errors++; $display("FAIL wr_ready aw=%b w=%b exp=1,1", lsu_awready, lsu_wready);
    end
    tick;
    lsu_awvalid = 0; lsu_wvalid = 0; mem_awready = 0; mem_wready = 0;
    tick;
    mem_bvalid = 1; mem_bresp = 2'b00; #1;
    checks++;
    if (lsu_bvalid !== 1'b1 || mem_bready !== 1'b1 || lsu_arready !== 1'b0) begin
      errors++; $display("FAIL wr_bresp bvalid=%b bready=%b lsu_ar=%b exp=1,1,0", lsu_bvalid, mem_bready, lsu_arready);
    end
    tick;
    mem_bvalid = 0; #1;
    checks++;
    if (lsu_bvalid !== 1'b0 || mem_awvalid !== 1'b0 || mem_arvalid !== 1'b0) begin
      errors++; $display("FAIL wr_idle bvalid=%b awvalid=%b arvalid=%b exp=0,0,0", lsu_bvalid, mem_awvalid, mem_arvalid);
    end
    // pending LSU read is served after the idle cycle
    tick; #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0300) begin
      errors++; $display("FAIL wr_then_rd arvalid=%b addr=%h exp=1,80000300", mem_arvalid, mem_araddr);
    end
    mem_arready = 1; lsu_rready = 1;
    tick;
    lsu_arvalid = 0; mem_arready = 0; mem_rvalid = 1;
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_rresp_err;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0400; ifu_rready = 1;
    tick;
    ifu_arvalid = 0; #1;  // granted master withdraws without handshake
    tick;
    ifu_arvalid = 1; lsu_arvalid = 1; lsu_araddr = 32'h8000_0500; lsu_rready = 1; #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0400) begin
      errors++; $display("FAIL grant_held arvalid=%b addr=%h exp=1,80000400", mem_arvalid, mem_araddr);
    end
    mem_arready = 1;
    tick;
    ifu_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001; mem_rresp = 2'b10; #1;
    checks++;
    if (ifu_rresp !== 2'b10 || ifu_rdata !== 32'hCAFE_0001 || lsu_rvalid !== 1'b0) begin
      errors++; $display("FAIL rresp_err resp=%b data=%h lsu_rvalid=%b exp=10,cafe0001,0", ifu_rresp, ifu_rdata, lsu_rvalid);
    end
    tick;
    mem_rvalid = 0; mem_rresp = 2'b00; #1;
    checks++;
    if (mem_arvalid !== 1'b0 || lsu_arready !== 1'b0) begin
      errors++; $display("FAIL err_release arvalid=%b lsu_ar=%b exp=0,0", mem_arvalid, lsu_arready);
    end
    tick; #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0500) begin
      errors++; $display("FAIL err_next arvalid=%b addr=%h exp=1,80000500", mem_arvalid, mem_araddr);
    end
    mem_arready = 1;
    tick;
    lsu_arvalid = 0; mem_arready = 0; mem_rvalid = 1;
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_reset_mid;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0020; lsu_wvalid = 1; lsu_wdata = 32'h1111_2222;
    lsu_wstrb = 4'hF; lsu_bready = 1;
    tick;
    mem_awready = 1; mem_wready = 1;
    tick;
    lsu_awvalid = 0; lsu_wvalid = 0; mem_awready = 0; mem_wready = 0;
    mem_bvalid = 1; rst = 1; #1;
    checks++;
    if (lsu_bvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre bvalid=%b exp=1", lsu_bvalid); end
    tick; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstmid_idle got=%h exp=0", all_out); end
    rst = 0;
    tick; #1;
    checks++;
    if (lsu_bvalid !== 1'b0 || mem_bready !== 1'b0) begin
      errors++; $display("FAIL rstmid_discard bvalid=%b bready=%b exp=0,0", lsu_bvalid, mem_bready);
    end
    idle_inputs;
    tick;
  endtask

  // Both masters request continuously; grant order is fixed-LSU or alternating.
  task automatic test_back_to_back;
    logic [31:0] exp_addr;
    apply_reset;
    ifu_arvalid = 1; ifu_araddr = 32'h0000_0100; ifu_rready = 1;
    lsu_arvalid = 1; lsu_araddr = 32'h0000_0200; lsu_rready = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      mem_arready = 1; #1;
      exp_addr = (RR && (i % 2 == 1)) ? 32'h0000_0100 : 32'h0000_0200;
      checks++;
      if (mem_araddr !== exp_addr) begin
        errors++; $display("FAIL b2b_grant%0d addr=%h exp=%h", i, mem_araddr, exp_addr);
      end
      tick;
      mem_arready = 0; mem_rvalid = 1;
      tick;
      mem_rvalid = 0;
    end
    idle_inputs;
    apply_reset;
  endtask

  // Random traffic: masters and slave are modelled at transaction level.
  task automatic test_random;
    int own;          // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
    bit last_lsu_m;
    int ifu_ph, lsu_ph;  // 0 idle, 1 addr, 2 wait rdata; lsu 3 write, 4 wait bresp
    logic [31:0] ifu_a, lsu_a, lsu_d, rd_d;
    logic [3:0] lsu_s;
    logic [1:0] rd_r, br;
    bit rd_pend, rv_on, wr_pend, bv_on, lsu_any, lsu_wr, lsu_first, r_hs, b_hs;
    logic e_ifu_arready, e_ifu_rvalid, e_lsu_arready, e_lsu_rvalid, e_lsu_awready, e_lsu_wready, e_lsu_bvalid;
    logic [31:0] e_ifu_rdata, e_lsu_rdata, e_mem_araddr, e_mem_awaddr, e_mem_wdata;
    logic [1:0] e_ifu_rresp, e_lsu_rresp, e_lsu_bresp;
    logic e_mem_arvalid, e_mem_rready, e_mem_awvalid, e_mem_wvalid, e_mem_bready;
    logic [3:0] e_mem_wstrb;
    logic [255:0] e_vec;
    apply_reset;
    own = 0; last_lsu_m = 0; ifu_ph = 0; lsu_ph = 0;
    rd_pend = 0; rv_on = 0; wr_pend = 0; bv_on = 0;
    rd_d = '0; rd_r = '0; br = '0; ifu_a = '0; lsu_a = '0; lsu_d = '0; lsu_s = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ifu_ph == 0 && $urandom_range(0, 3) == 0) begin ifu_ph = 1; ifu_a = $urandom & 32'hFFFF_FFFC; end
      if (lsu_ph == 0 && $urandom_range(0, 3) == 0) begin
        lsu_ph = ($urandom_range(0, 1) != 0) ? 1 : 3;
        lsu_a = $urandom & 32'hFFFF_FFFC; lsu_d = $urandom; lsu_s = 4'($urandom_range(0, 15));
      end
      ifu_arvalid = (ifu_ph == 1); ifu_araddr = (ifu_ph == 1) ? ifu_a : $urandom;
      ifu_rready  = ($urandom_range(0, 3) != 0);
      lsu_arvalid = (lsu_ph == 1); lsu_araddr = (lsu_ph == 1) ? lsu_a : $urandom;
      lsu_awvalid = (lsu_ph == 3); lsu_wvalid = (lsu_ph == 3);
      lsu_awaddr  = (lsu_ph == 3) ? lsu_a : $urandom;
      lsu_wdata   = (lsu_ph == 3) ? lsu_d : $urandom;
      lsu_wstrb   = (lsu_ph == 3) ? lsu_s : 4'($urandom_range(0, 15));
      lsu_rready  = ($urandom_range(0, 3) != 0);
      lsu_bready  = ($urandom_range(0, 3) != 0);
      mem_arready = !rd_pend && ($urandom_range(0, 1) != 0);
      if (rd_pend && !rv_on && ($urandom_range(0, 1) != 0)) rv_on = 1;
      mem_rvalid = rv_on; mem_rdata = rv_on ? rd_d : $urandom; mem_rresp = rv_on ? rd_r : 2'($urandom_range(0, 3));
      mem_awready = !wr_pend && ($urandom_range(0, 1) != 0); mem_wready = mem_awready;
      if (wr_pend && !bv_on && ($urandom_range(0, 1) != 0)) bv_on = 1;
      mem_bvalid = bv_on; mem_bresp = bv_on ? br : 2'($urandom_range(0, 3));
      #1;
      e_ifu_arready = 0; e_ifu_rvalid = 0; e_ifu_rdata = '0; e_ifu_rresp = '0;
      e_lsu_arready = 0; e_lsu_rvalid = 0; e_lsu_rdata = '0; e_lsu_rresp = '0;
      e_lsu_awready = 0; e_lsu_wready = 0; e_lsu_bvalid = 0; e_lsu_bresp = '0;
      e_mem_arvalid = 0; e_mem_araddr = '0; e_mem_rready = 0; e_mem_awvalid = 0; e_mem_awaddr = '0;
      e_mem_wvalid = 0; e_mem_wdata = '0; e_mem_wstrb = '0; e_mem_bready = 0;
      if (own == 1) begin
        e_mem_arvalid = ifu_arvalid; e_mem_araddr = ifu_araddr; e_mem_rready = ifu_rready;
        e_ifu_arready = mem_arready; e_ifu_rvalid = mem_rvalid; e_ifu_rdata = mem_rdata; e_ifu_rresp = mem_rresp;
      end else if (own == 2) begin
        e_mem_arvalid = lsu_arvalid; e_mem_araddr = lsu_araddr; e_mem_rready = lsu_rready;
        e_lsu_arready = mem_arready; e_lsu_rvalid = mem_rvalid; e_lsu_rdata = mem_rdata; e_lsu_rresp = mem_rresp;
      end else if (own == 3) begin
        e_mem_awvalid = lsu_awvalid; e_mem_awaddr = lsu_awaddr; e_mem_wvalid = lsu_wvalid;
        e_mem_wdata = lsu_wdata; e_mem_wstrb = lsu_wstrb; e_mem_bready = lsu_bready;
        e_lsu_awready = mem_awready; e_lsu_wready = mem_wready; e_lsu_bvalid = mem_bvalid; e_lsu_bresp = mem_bresp;
      end
      e_vec = 256'({e_ifu_arready, e_ifu_rvalid, e_ifu_rdata, e_ifu_rresp,
                     e_lsu_arready, e_lsu_rvalid, e_lsu_rdata, e_lsu_rresp,
                     e_lsu_awready, e_lsu_wready, e_lsu_bvalid, e_lsu_bresp,
                     e_mem_arvalid, e_mem_araddr, e_mem_rready, e_mem_awvalid, e_mem_awaddr,
                     e_mem_wvalid, e_mem_wdata, e_mem_wstrb, e_mem_bready});
      checks++;
      if (all_out !== e_vec) begin
        errors++; $display("FAIL rand_route cyc=%0d owner=%0d got=%h exp=%h", cyc, own, all_out, e_vec);
      end
      r_hs = rv_on && e_mem_rready;
      b_hs = bv_on && e_mem_bready;
      if (r_hs) begin
        checks++;
        if (own == 1 && (ifu_rdata !== mem_word(ifu_a) || ifu_rresp !== rd_r)) begin
          errors++; $display("FAIL rand_ifu_data got=%h/%b exp=%h/%b", ifu_rdata, ifu_rresp, mem_word(ifu_a), rd_r);
        end else if (own == 2 && (lsu_rdata !== mem_word(lsu_a) || lsu_rresp !== rd_r)) begin
          errors++; $display("FAIL rand_lsu_data got=%h/%b exp=%h/%b", lsu_rdata, lsu_rresp, mem_word(lsu_a), rd_r);
        end
        if (own == 1) ifu_ph = 0; else lsu_ph = 0;
        rd_pend = 0; rv_on = 0;
      end
      if (b_hs) begin
        checks++;
        if (lsu_bresp !== br) begin errors++; $display("FAIL rand_bresp got=%b exp=%b", lsu_bresp, br); end
        lsu_ph = 0; wr_pend = 0; bv_on = 0;
      end
      if (e_mem_arvalid && mem_arready) begin
        rd_pend = 1; rd_d = mem_word(e_mem_araddr);
        rd_r = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        if (own == 1) ifu_ph = 2; else lsu_ph = 2;
      end
      if (e_mem_awvalid && e_mem_wvalid && mem_awready) begin
        checks++;
        if (mem_awaddr !== lsu_a || mem_wdata !== lsu_d || mem_wstrb !== lsu_s) begin
          errors++; $display("FAIL rand_wr_payload got=%h/%h/%b exp=%h/%h/%b", mem_awaddr, mem_wdata, mem_wstrb, lsu_a, lsu_d, lsu_s);
        end
        wr_pend = 1; br = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00; lsu_ph = 4;
      end
      if (own == 0) begin
        lsu_wr    = lsu_awvalid && lsu_wvalid;
        lsu_any   = lsu_arvalid || lsu_wr;
        lsu_first = !(RR && last_lsu_m);
        if (lsu_any && (lsu_first || !ifu_arvalid)) own = lsu_wr ? 3 : 2;
        else if (ifu_arvalid) own = 1;
        if (own != 0) last_lsu_m = (own != 1);
      end else if ((own == 1 || own == 2) && r_hs) begin
        own = 0;
      end else if (own == 3 && b_hs) begin
        own = 0;
      end
      tick;
    end
    idle_inputs;
    apply_reset;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    idle_inputs;
    rst = 1;
    tick;
    test_reset;
    test_ifu_read;
    test_contention;
    test_lsu_write;
    test_rresp_err;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
